// File: rtl/match_run_logger.sv
// Run-length logger for detector match bits.
// Completed runs are queued as {sat, len} records for a valid/ready reader.
module match_run_logger #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     match_in,
    input  logic                     clear,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [CNT_W-1:0]         rd_len,
    output logic                     rd_sat,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_sat_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_push;

    logic [CNT_W:0]     r_mem [DEPTH];
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic               r_ovf;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;
    logic [CNT_W:0]     w_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (match_in)  w_state_nxt = S_RUN;
            S_RUN:  if (!match_in) w_state_nxt = S_IDLE;
        endcase
    end

    assign w_cnt_inc = (r_cnt == MAX) ? MAX : r_cnt + ONE;

    always_comb begin
        w_push    = 1'b0;
        w_cnt_nxt = r_cnt;
        w_sat_nxt = r_sat;
        unique case (r_state)
            S_IDLE: begin
                if (match_in) begin
                    w_cnt_nxt = ONE;
                    w_sat_nxt = (ONE == MAX);
                end
            end
            S_RUN: begin
                if (match_in) begin
                    w_cnt_nxt = w_cnt_inc;
                    w_sat_nxt = r_sat | (w_cnt_inc == MAX);
                end else begin
                    w_push    = 1'b1;
                    w_cnt_nxt = '0;
                    w_sat_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_sat <= w_sat_nxt;
        end
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && rd_ready;
    // A pop frees the slot the same edge, so a full FIFO can still accept.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= {r_sat, r_cnt};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_drop)     r_ovf <= 1'b1;
            else if (clear) r_ovf <= 1'b0;
        end
    end

    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign rd_valid   = !w_empty;
    assign rd_len     = rd_valid ? w_head[CNT_W-1:0] : '0;
    assign rd_sat     = rd_valid ? w_head[CNT_W] : 1'b0;
    assign fifo_count = r_wptr - r_rptr;
    assign overflow   = r_ovf;

endmodule
